uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
- Sits inside the FPGA top level, between the UART receiver byte output and the core instruction/data RAM write port.
- Parses a length-prefixed program image arriving as bytes and writes 32-bit little-endian words into RAM starting at word address 0.
- Holds the core in reset until the image is complete.
- Drives the program_receiving / program_ov / program_done status LEDs.

Parameters:
- ADDR_WIDTH, 12, RAM word-address width.
- MEM_WORDS, 4096, RAM capacity in words (must be <= 2**ADDR_WIDTH).
- TIMEOUT_CYCLES, 5000000, maximum idle clocks between bytes once a load has started.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_valid  input  1  one-cycle strobe; rx_data is valid.
- rx_data  input  8  received byte.
- mem_we  output  1  RAM write strobe, one cycle per word.
- mem_addr  output  ADDR_WIDTH  RAM word address.
- mem_wdata  output  32  RAM write data.
- core_reset  output  1  holds the core in reset while high.
- program_receiving  output  1  a load is in progress.
- program_ov  output  1  sticky: the header length exceeded MEM_WORDS.
- program_done  output  1  sticky: the image was written successfully.
- load_timeout  output  1  one-cycle pulse when an in-progress load is aborted by the inter-byte timeout.
- program_csum_err  output  1  sticky checksum mismatch; tied to 0 without CHECKSUM_EN.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset values:
  - All outputs 0, except core_reset = 1.
  - State = LEN; byte counter, word counter, length and timeout counter = 0.
- Image format:
  - 4-byte little-endian word count N.
  - Then N×4 data bytes; each word is little-endian (the first byte goes to bits [7:0]).
- States: LEN, DATA, CSUM (only with CHECKSUM_EN), DONE, OVF.
- LEN:
  - Shift bytes into the length register.
  - program_receiving rises the cycle after the first header byte.
  - On the 4th byte:
    - N == 0 → DONE.
    - N > MEM_WORDS → OVF.
    - Otherwise → DATA.
- DATA:
  - Assemble 4 bytes per word.
  - The cycle after the 4th byte's rx_valid: mem_we = 1, mem_addr = word counter, mem_wdata = assembled word; the word counter then increments.
  - After word N-1 is written → DONE.
  - mem_addr never exceeds N-1; there is no wrap-around.
- DONE:
  - program_done = 1 and program_receiving = 0.
  - core_reset falls in the same cycle program_done rises.
  - All further bytes are ignored until reset.
- OVF:
  - program_ov = 1, program_receiving = 0, core_reset stays 1.
  - No RAM writes; bytes are ignored until reset.
- Timeout:
  - The counter runs while a load is in progress (LEN with at least 1 byte received, DATA, CSUM) and clears on every rx_valid.
  - On reaching TIMEOUT_CYCLES-1: load_timeout pulses, all counters clear, state → LEN, program_receiving = 0.
  - Words already written stay in RAM; the next byte starts a fresh header.
- Simultaneous events: if rx_valid arrives in the same cycle as timeout expiry, the byte wins (counter clears, no abort).
- Reset mid-load: returns to LEN immediately and core_reset re-asserts.
- No backpressure: every rx_valid byte is consumed in its own cycle, and back-to-back strobes are legal.

Optional Feature:
- Macro: UART_LOADER_CHECKSUM_EN.
- When defined:
  - After the last data word, the state goes to CSUM and expects one byte equal to the 8-bit modular sum of all 4N data bytes.
  - Match → DONE.
  - Mismatch → program_csum_err = 1 (sticky); core_reset stays 1 and the state parks until reset.
  - N == 0 still expects a checksum byte of 0x00.
- When undefined: no CSUM state, no sum register, program_csum_err is constant 0.

Decomposition:
- Package uart_loader_pkg:
  - state enum loader_state_e.
  - HDR_BYTES = 4, BYTES_PER_WORD = 4.
  - Default TIMEOUT_CYCLES constant.
- Sub-module uart_loader_timeout: a loadable down-counter with clear and expire outputs, instantiated once.

Test Plan:
- Normal load: header 02 00 00 00, then bytes 78 56 34 12 EF BE AD DE → mem_we at addr 0 with 0x12345678, then addr 1 with 0xDEADBEEF; program_done = 1 and core_reset = 0 the cycle after the last write.
- Zero length: header 00 00 00 00 → DONE with no mem_we; later bytes AA BB produce no writes.
- Overflow with MEM_WORDS = 4: header 05 00 00 00 → program_ov = 1, core_reset = 1; 20 following bytes produce no mem_we.
- Timeout with TIMEOUT_CYCLES = 100: header 03 00 00 00 plus 2 data bytes, then idle → load_timeout pulse exactly 100 cycles after the last byte, state LEN; a fresh 1-word image then loads at addr 0.
- Timing corner: a byte strobed on the expiry cycle → no timeout pulse; back-to-back rx_valid for 8 cycles → both words are written correctly.
- With UART_LOADER_CHECKSUM_EN: 1-word image 01 02 03 04 with checksum 0x0A → DONE; the same image with checksum 0x0B → program_csum_err = 1, core_reset stays 1.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
// UART_LOADER_CHECKSUM_EN adds the trailing checksum state.
package uart_loader_pkg;

    localparam int HDR_BYTES              = 4;
    localparam int BYTES_PER_WORD         = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 5000000;

`ifdef UART_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_OVF} loader_state_e;
`else
    typedef enum logic [2:0] {S_LEN, S_DATA, S_DONE, S_OVF} loader_state_e;
`endif

endpackage

// File: rtl/uart_loader_timeout.sv
// Inter-byte watchdog: reloads on every byte, counts down while a load runs,
// flags expiry when it reaches zero while enabled.
module uart_loader_timeout
    import uart_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = CW'(TIMEOUT_CYCLES - 1);
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_program_loader.sv
// Length-prefixed UART program loader: writes little-endian words to RAM from
// address 0 and releases core reset on completion. Option: UART_LOADER_CHECKSUM_EN.
module uart_program_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int MEM_WORDS      = 4096,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_reset,
    output logic                  program_receiving,
    output logic                  program_ov,
    output logic                  program_done,
    output logic                  load_timeout,
    output logic                  program_csum_err
);

    localparam logic [1:0] LAST_HDR  = 2'(HDR_BYTES - 1);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    loader_state_e         state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [31:0]           len_q, len_d;
    logic [23:0]           data_q, data_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  timeout_q, timeout_d;
    logic                  busy, expire, abort;
    logic [31:0]           len_full, word_full;

    assign len_full  = {rx_data, len_q[31:8]};
    assign word_full = {rx_data, data_q};

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       csum_err_q, csum_err_d;
    assign busy = (state_q == S_LEN && byte_cnt_q != '0) || state_q == S_DATA ||
                  (state_q == S_CSUM && !csum_err_q);
`else
    assign busy = (state_q == S_LEN && byte_cnt_q != '0) || state_q == S_DATA;
`endif

    // A byte arriving on the expiry cycle keeps the load alive.
    assign abort = expire && !rx_valid;

    uart_loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .load_i   (rx_valid),
        .clr_i    (abort),
        .en_i     (busy),
        .expire_o (expire)
    );

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        data_d     = data_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        timeout_d  = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        csum_err_d = csum_err_q;
`endif
        case (state_q)
            S_LEN: if (rx_valid) begin
                byte_cnt_d = byte_cnt_q + 2'd1;
                len_d      = len_full;
                if (byte_cnt_q == LAST_HDR) begin
                    byte_cnt_d = '0;
                    if (len_full == '0)
`ifdef UART_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    else if (len_full > 32'(MEM_WORDS))
                        state_d = S_OVF;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
`ifndef UART_LOADER_CHECKSUM_EN
                // One settle cycle after the final write before releasing the core.
                if (32'(word_cnt_q) == len_q)
                    state_d = S_DONE;
                else
`endif
                if (rx_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    data_d     = word_full[31:8];
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + rx_data;
`endif
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        we_d       = 1'b1;
                        addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
                        wdata_d    = word_full;
                        word_cnt_d = word_cnt_q + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                        if (32'(word_cnt_q) + 32'd1 == len_q)
                            state_d = S_CSUM;
`endif
                    end
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            S_CSUM: if (rx_valid && !csum_err_q) begin
                if (rx_data == sum_q) state_d    = S_DONE;
                else                  csum_err_d = 1'b1;
            end
`endif
            default: ;
        endcase

        if (abort) begin
            state_d    = S_LEN;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            len_d      = '0;
            timeout_d  = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_d      = '0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_LEN;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            timeout_q  <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            csum_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            data_q     <= data_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            timeout_q  <= timeout_d;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            csum_err_q <= csum_err_d;
`endif
        end
    end

    assign mem_we            = we_q;
    assign mem_addr          = addr_q;
    assign mem_wdata         = wdata_q;
    assign core_reset        = (state_q != S_DONE);
    assign program_receiving = busy;
    assign program_ov        = (state_q == S_OVF);
    assign program_done      = (state_q == S_DONE);
    assign load_timeout      = timeout_q;
`ifdef UART_LOADER_CHECKSUM_EN
    assign program_csum_err  = csum_err_q;
`else
    assign program_csum_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader (MEM_WORDS=4, TIMEOUT_CYCLES=100).
module tb_uart_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_reset, program_receiving, program_ov, program_done;
    logic        load_timeout, program_csum_err;

    int checks = 0;
    int failures = 0;

    uart_program_loader #(.ADDR_WIDTH(12), .MEM_WORDS(4), .TIMEOUT_CYCLES(100)) dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_reset(core_reset), .program_receiving(program_receiving),
        .program_ov(program_ov), .program_done(program_done),
        .load_timeout(load_timeout), .program_csum_err(program_csum_err)
    );

    always #5 clock = ~clock;

    // Write log; tasks compare deltas against a snapshot of wr_count.
    int          wr_count = 0;
    logic [11:0] wa [0:63];
    logic [31:0] wd [0:63];
    always @(negedge clock) begin
        if (mem_we) begin
            wa[wr_count % 64] <= mem_addr;
            wd[wr_count % 64] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        checks += 7;
        if (mem_we !== 1'b0)            begin failures++; $display("FAIL rst_we got=%b exp=0", mem_we); end
        if (core_reset !== 1'b1)        begin failures++; $display("FAIL rst_core got=%b exp=1", core_reset); end
        if (program_receiving !== 1'b0) begin failures++; $display("FAIL rst_recv got=%b exp=0", program_receiving); end
        if (program_ov !== 1'b0)        begin failures++; $display("FAIL rst_ov got=%b exp=0", program_ov); end
        if (program_done !== 1'b0)      begin failures++; $display("FAIL rst_done got=%b exp=0", program_done); end
        if (load_timeout !== 1'b0)      begin failures++; $display("FAIL rst_to got=%b exp=0", load_timeout); end
        if (program_csum_err !== 1'b0)  begin failures++; $display("FAIL rst_csum got=%b exp=0", program_csum_err); end
        reset = 1'b0;
        send_byte(8'h02);
        checks++;
        if (program_receiving !== 1'b1) begin failures++; $display("FAIL recv_first got=%b exp=1", program_receiving); end
        reset = 1'b1;
        idle(1);
        checks += 2;
        if (program_receiving !== 1'b0) begin failures++; $display("FAIL midrst_recv got=%b exp=0", program_receiving); end
        if (core_reset !== 1'b1)        begin failures++; $display("FAIL midrst_core got=%b exp=1", core_reset); end
        reset = 1'b0;
    endtask

    task automatic test_normal();
        int base;
        do_reset();
        base = wr_count;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        checks += 3;
        if (mem_we !== 1'b1)             begin failures++; $display("FAIL w0_we got=%b exp=1", mem_we); end
        if (mem_addr !== 12'd0)          begin failures++; $display("FAIL w0_addr got=%0d exp=0", mem_addr); end
        if (mem_wdata !== 32'h12345678)  begin failures++; $display("FAIL w0_data got=%h exp=12345678", mem_wdata); end
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        checks += 4;
        if (mem_we !== 1'b1)             begin failures++; $display("FAIL w1_we got=%b exp=1", mem_we); end
        if (mem_addr !== 12'd1)          begin failures++; $display("FAIL w1_addr got=%0d exp=1", mem_addr); end
        if (mem_wdata !== 32'hDEADBEEF)  begin failures++; $display("FAIL w1_data got=%h exp=deadbeef", mem_wdata); end
        if (program_done !== 1'b0)       begin failures++; $display("FAIL w1_early_done got=%b exp=0", program_done); end
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(8'h4C);
`else
        idle(1);
`endif
        #1;
        checks += 5;
        if (program_done !== 1'b1)      begin failures++; $display("FAIL norm_done got=%b exp=1", program_done); end
        if (core_reset !== 1'b0)        begin failures++; $display("FAIL norm_core got=%b exp=0", core_reset); end
        if (program_receiving !== 1'b0) begin failures++; $display("FAIL norm_recv got=%b exp=0", program_receiving); end
        if (program_csum_err !== 1'b0)  begin failures++; $display("FAIL norm_csum got=%b exp=0", program_csum_err); end
        if (wr_count - base !== 2)      begin failures++; $display("FAIL norm_wrcount got=%0d exp=2", wr_count - base); end
    endtask

    task automatic test_zero_length();
        int base;
        do_reset();
        base = wr_count;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        checks += 2;
        if (program_done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", program_done); end
        if (core_reset !== 1'b0)   begin failures++; $display("FAIL zero_core got=%b exp=0", core_reset); end
        send_byte(8'hAA); send_byte(8'hBB);
        idle(3);
        #1;
        checks += 2;
        if (wr_count - base !== 0) begin failures++; $display("FAIL zero_writes got=%0d exp=0", wr_count - base); end
        if (program_done !== 1'b1) begin failures++; $display("FAIL zero_sticky got=%b exp=1", program_done); end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        base = wr_count;
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        checks += 3;
        if (program_ov !== 1'b1)        begin failures++; $display("FAIL ov_flag got=%b exp=1", program_ov); end
        if (core_reset !== 1'b1)        begin failures++; $display("FAIL ov_core got=%b exp=1", core_reset); end
        if (program_receiving !== 1'b0) begin failures++; $display("FAIL ov_recv got=%b exp=0", program_receiving); end
        for (int i = 0; i < 20; i++) send_byte(8'(i + 1));
        idle(2);
        #1;
        checks += 3;
        if (wr_count - base !== 0) begin failures++; $display("FAIL ov_writes got=%0d exp=0", wr_count - base); end
        if (program_ov !== 1'b1)   begin failures++; $display("FAIL ov_sticky got=%b exp=1", program_ov); end
        if (program_done !== 1'b0) begin failures++; $display("FAIL ov_done got=%b exp=0", program_done); end
        // N == MEM_WORDS is the largest legal image
        do_reset();
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        checks += 2;
        if (program_ov !== 1'b0)        begin failures++; $display("FAIL edge_ov got=%b exp=0", program_ov); end
        if (program_receiving !== 1'b1) begin failures++; $display("FAIL edge_recv got=%b exp=1", program_receiving); end
    endtask

    task automatic test_timeout();
        int base, hit;
        do_reset();
        base = wr_count;
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        hit = 0;
        for (int k = 1; k <= 150 && hit == 0; k++) begin
            @(negedge clock);
            if (load_timeout === 1'b1) hit = k;
        end
        checks += 3;
        if (hit !== 100)                begin failures++; $display("FAIL to_latency got=%0d exp=100", hit); end
        if (program_receiving !== 1'b0) begin failures++; $display("FAIL to_recv got=%b exp=0", program_receiving); end
        if (core_reset !== 1'b1)        begin failures++; $display("FAIL to_core got=%b exp=1", core_reset); end
        idle(1);
        checks++;
        if (load_timeout !== 1'b0) begin failures++; $display("FAIL to_pulse_width got=%b exp=0", load_timeout); end
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(8'hAA);
`else
        idle(1);
`endif
        #1;
        checks += 4;
        if (wr_count - base !== 1)      begin failures++; $display("FAIL to_wrcount got=%0d exp=1", wr_count - base); end
        if (wa[base % 64] !== 12'd0)    begin failures++; $display("FAIL to_addr got=%0d exp=0", wa[base % 64]); end
        if (wd[base % 64] !== 32'h11223344) begin failures++; $display("FAIL to_data got=%h exp=11223344", wd[base % 64]); end
        if (program_done !== 1'b1)      begin failures++; $display("FAIL to_done got=%b exp=1", program_done); end
    endtask

    task automatic test_expiry_byte();
        int base, pulses;
        do_reset();
        base = wr_count;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01);
        idle(99);
        pulses = 0;
        send_byte(8'h02);
        if (load_timeout === 1'b1) pulses++;
        checks += 2;
        if (pulses !== 0)               begin failures++; $display("FAIL exp_pulse got=%0d exp=0", pulses); end
        if (program_receiving !== 1'b1) begin failures++; $display("FAIL exp_recv got=%b exp=1", program_receiving); end
        send_byte(8'h03); send_byte(8'h04);
        idle(1);
        #1;
        checks += 2;
        if (wr_count - base !== 1)          begin failures++; $display("FAIL exp_wrcount got=%0d exp=1", wr_count - base); end
        if (wd[base % 64] !== 32'h04030201) begin failures++; $display("FAIL exp_data got=%h exp=04030201", wd[base % 64]); end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        base = wr_count;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        send_byte(8'h05); send_byte(8'h16); send_byte(8'h27); send_byte(8'h38);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(8'h64);
`else
        idle(1);
`endif
        #1;
        checks += 6;
        if (wr_count - base !== 2)               begin failures++; $display("FAIL b2b_wrcount got=%0d exp=2", wr_count - base); end
        if (wa[base % 64] !== 12'd0)             begin failures++; $display("FAIL b2b_addr0 got=%0d exp=0", wa[base % 64]); end
        if (wd[base % 64] !== 32'hD4C3B2A1)      begin failures++; $display("FAIL b2b_data0 got=%h exp=d4c3b2a1", wd[base % 64]); end
        if (wa[(base + 1) % 64] !== 12'd1)       begin failures++; $display("FAIL b2b_addr1 got=%0d exp=1", wa[(base + 1) % 64]); end
        if (wd[(base + 1) % 64] !== 32'h38271605) begin failures++; $display("FAIL b2b_data1 got=%h exp=38271605", wd[(base + 1) % 64]); end
        if (program_done !== 1'b1)               begin failures++; $display("FAIL b2b_done got=%b exp=1", program_done); end
    endtask

`ifdef UART_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h0A);
        checks += 2;
        if (program_done !== 1'b1)     begin failures++; $display("FAIL cs_ok_done got=%b exp=1", program_done); end
        if (program_csum_err !== 1'b0) begin failures++; $display("FAIL cs_ok_err got=%b exp=0", program_csum_err); end
        do_reset();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h0B);
        send_byte(8'h0A);
        idle(2);
        checks += 3;
        if (program_csum_err !== 1'b1) begin failures++; $display("FAIL cs_bad_err got=%b exp=1", program_csum_err); end
        if (core_reset !== 1'b1)       begin failures++; $display("FAIL cs_bad_core got=%b exp=1", core_reset); end
        if (program_done !== 1'b0)     begin failures++; $display("FAIL cs_bad_done got=%b exp=0", program_done); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        test_reset();
        test_normal();
        test_zero_length();
        test_overflow();
        test_timeout();
        test_expiry_byte();
        test_back_to_back();
`ifdef UART_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
